// File: rtl/dcache_l1.sv
`default_nettype none
// ============================================================================
// Module   : dcache_l1
// Purpose  : Direct-mapped write-back/write-allocate L1 data cache, 32-byte
//            lines, zero-latency hits, line-granular memory handshake.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_l1 #(
    parameter int NUM_LINES = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_i,
    input  logic         we_i,
    input  logic [31:0]  addr_i,
    input  logic [31:0]  wdata_i,
    output logic [31:0]  rdata_o,
    output logic         stall_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    localparam int c_INDEX_W = $clog2(NUM_LINES);
    localparam int c_TAG_W   = 27 - c_INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2,
        S_REFILL    = 2'd3
    } state_t;

    state_t                 r_state;
    logic [NUM_LINES-1:0]   r_valid;
    logic [NUM_LINES-1:0]   r_dirty;
    logic [c_TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [255:0]           r_data [NUM_LINES];

    logic [c_INDEX_W-1:0]   w_index;
    logic [c_TAG_W-1:0]     w_tag;
    logic [2:0]             w_word;
    logic [255:0]           w_line;
    logic                   w_hit;
    logic                   w_idle;
    logic                   w_idle_hit;
    logic [1:0]             w_unused_addr;

    assign w_index       = addr_i[4+c_INDEX_W:5];
    assign w_tag         = addr_i[31:5+c_INDEX_W];
    assign w_word        = addr_i[4:2];
    assign w_unused_addr = addr_i[1:0];
    assign w_line        = r_data[w_index];
    assign w_hit         = req_i & r_valid[w_index] & (r_tag[w_index] == w_tag);
    assign w_idle        = (r_state == S_IDLE);
    // Hits only count in IDLE; the REFILL cycle also matches but is still stalled.
    assign w_idle_hit    = w_idle & w_hit;

    assign rdata_o      = (w_idle_hit & ~we_i) ? w_line[{w_word, 5'b00000} +: 32] : 32'd0;
    assign stall_o      = ~w_idle | (req_i & ~w_hit);
    assign mem_enable_o = (r_state == S_WRITEBACK) | (r_state == S_ALLOCATE);
    assign mem_write_o  = (r_state == S_WRITEBACK);
    assign mem_data_o   = (r_state == S_WRITEBACK) ? w_line : 256'd0;

    always_comb begin
        mem_addr_o = 32'd0;
        if (r_state == S_WRITEBACK)
            mem_addr_o = {r_tag[w_index], w_index, 5'b00000};
        else if (r_state == S_ALLOCATE)
            mem_addr_o = {w_tag, w_index, 5'b00000};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_i & ~w_hit)
                        r_state <= (r_valid[w_index] & r_dirty[w_index]) ? S_WRITEBACK : S_ALLOCATE;
                    else if (w_hit & we_i)
                        r_dirty[w_index] <= 1'b1;
                end
                S_WRITEBACK: begin
                    if (mem_ack_i)
                        r_state <= S_ALLOCATE;
                end
                S_ALLOCATE: begin
                    if (mem_ack_i) begin
                        r_valid[w_index] <= 1'b1;
                        r_dirty[w_index] <= 1'b0;
                        r_state          <= S_REFILL;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag and data arrays need no reset; the valid bits qualify them.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (w_idle_hit & we_i)
                r_data[w_index][{w_word, 5'b00000} +: 32] <= wdata_i;
            else if ((r_state == S_ALLOCATE) & mem_ack_i) begin
                r_data[w_index] <= mem_data_i;
                r_tag[w_index]  <= w_tag;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_l1.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_l1
// Purpose  : Scoreboard bench for dcache_l1 with a responding memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_l1;

    logic         clk;
    logic         rst_i;
    logic         req_i;
    logic         we_i;
    logic [31:0]  addr_i;
    logic [31:0]  wdata_i;
    logic [31:0]  rdata_o;
    logic         stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    dcache_l1 #(.NUM_LINES(32)) u_dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rdata_o      (rdata_o),
        .stall_o      (stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } mem_exp_t;

    logic [31:0] exp_load_q [$];
    mem_exp_t    exp_mem_q  [$];

    int checks   = 0;
    int failures = 0;
    int ack_delay = 0;
    int ack_cnt   = 0;
    bit hold_ack  = 0;
    bit stray_ack = 0;

    // Fixed backing-memory contents: word i of a line is base + i.
    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [31:0]  base;
        logic [255:0] l;
        case ({a[31:5], 5'b00000})
            32'h0000_0040: base = 32'h10;
            32'h0000_0440: base = 32'h20;
            32'h0000_0800: base = 32'h30;
            32'h0000_0000: base = 32'h50;
            default:       base = 32'hA0;
        endcase
        for (int i = 0; i < 8; i++) l[32*i +: 32] = base + i;
        return l;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory responder plus monitor; both act on the falling edge.
    initial begin
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk);
            mem_data_i = '0;
            if (stray_ack) begin
                mem_ack_i = 1'b1;
                stray_ack = 0;
            end else if (mem_enable_o && !hold_ack && !rst_i) begin
                if (ack_cnt >= ack_delay) begin
                    mem_ack_i = 1'b1;
                    if (!mem_write_o) mem_data_i = line_of(mem_addr_o);
                    ack_cnt = 0;
                end else begin
                    mem_ack_i = 1'b0;
                    ack_cnt++;
                end
            end else begin
                mem_ack_i = 1'b0;
                ack_cnt = 0;
            end

            if (mem_ack_i && mem_enable_o) begin
                if (exp_mem_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL mem_unexpected: got wr=%0b addr=0x%08h expected none", mem_write_o, mem_addr_o);
                end else begin
                    mem_exp_t e;
                    e = exp_mem_q.pop_front();
                    check32("mem_write", {31'd0, mem_write_o}, {31'd0, e.wr});
                    check32("mem_addr", mem_addr_o, e.addr);
                    if (e.wr) begin
                        checks++;
                        if (mem_data_o !== e.data) begin
                            failures++;
                            $display("FAIL mem_wb_data: got %064h expected %064h", mem_data_o, e.data);
                        end
                    end
                end
            end

            if (req_i && !we_i && !stall_o && !rst_i) begin
                if (exp_load_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL load_unexpected: got 0x%08h expected none", rdata_o);
                end else begin
                    check32("load_rdata", rdata_o, exp_load_q.pop_front());
                end
            end
        end
    end

    task automatic push_mem(input logic wr, input logic [31:0] a, input logic [255:0] d);
        mem_exp_t e;
        e.wr = wr; e.addr = a; e.data = d;
        exp_mem_q.push_back(e);
    endtask

    // Issues one access, holding it through the stall, and checks the stall length.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input int exp_stall, input string name);
        int  n;
        bit  done;
        n = 0; done = 0;
        req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (stall_o) n++;
            else done = 1;
        end
        @(posedge clk); #1;
        req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL %s_timeout: got stall>60 expected %0d", name, exp_stall);
        end else begin
            check32({name, "_stall"}, n, exp_stall);
        end
    endtask

    initial begin
        logic [255:0] wb;
        bit seen;
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check32("rst_stall", {31'd0, stall_o}, 32'd0);
        check32("rst_mem_en", {31'd0, mem_enable_o}, 32'd0);
        check32("rst_mem_wr", {31'd0, mem_write_o}, 32'd0);
        check32("rst_rdata", rdata_o, 32'd0);
        check32("rst_mem_addr", mem_addr_o, 32'd0);
        check32("rst_mem_data_or", {31'd0, |mem_data_o}, 32'd0);
        @(posedge clk); #1;

        // Cold load, ack one cycle after the request opens.
        ack_delay = 1;
        push_mem(1'b0, 32'h40, '0);
        exp_load_q.push_back(32'h10);
        access(1'b0, 32'h40, 32'd0, 4, "cold_load");
        ack_delay = 0;
        exp_load_q.push_back(32'h11);
        access(1'b0, 32'h44, 32'd0, 0, "hit_load");
        access(1'b1, 32'h48, 32'hDEAD_BEEF, 0, "store_hit");
        exp_load_q.push_back(32'hDEAD_BEEF);
        access(1'b0, 32'h48, 32'd0, 0, "load_after_store");

        // Dirty eviction of index 2.
        wb = line_of(32'h40);
        wb[95:64] = 32'hDEAD_BEEF;
        push_mem(1'b1, 32'h40, wb);
        push_mem(1'b0, 32'h440, '0);
        exp_load_q.push_back(32'h20);
        access(1'b0, 32'h440, 32'd0, 4, "dirty_evict");

        // Write-allocate store miss, then evict it.
        push_mem(1'b0, 32'h800, '0);
        access(1'b1, 32'h800, 32'h1234_5678, 3, "store_miss");
        exp_load_q.push_back(32'h1234_5678);
        access(1'b0, 32'h800, 32'd0, 0, "load_alloc_store");
        wb = line_of(32'h800);
        wb[31:0] = 32'h1234_5678;
        push_mem(1'b1, 32'h800, wb);
        push_mem(1'b0, 32'h000, '0);
        exp_load_q.push_back(32'h50);
        access(1'b0, 32'h000, 32'd0, 4, "evict_store_line");

        // Reset during ALLOCATE before any ack.
        hold_ack = 1;
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h40;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (mem_enable_o) seen = 1;
        end
        check32("midmiss_alloc_seen", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        rst_i = 1'b1; req_i = 1'b0; addr_i = '0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        hold_ack = 0;
        @(negedge clk);
        check32("midmiss_mem_en", {31'd0, mem_enable_o}, 32'd0);
        check32("midmiss_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        stray_ack = 1;
        @(posedge clk); #1;
        @(negedge clk);
        check32("stray_mem_en", {31'd0, mem_enable_o}, 32'd0);
        check32("stray_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        push_mem(1'b0, 32'h440, '0);
        exp_load_q.push_back(32'h20);
        access(1'b0, 32'h440, 32'd0, 3, "post_reset_miss");

        // Back-to-back hit/miss with immediate acks.
        exp_load_q.push_back(32'h21);
        access(1'b0, 32'h444, 32'd0, 0, "b2b_hit0");
        push_mem(1'b0, 32'h000, '0);
        exp_load_q.push_back(32'h50);
        access(1'b0, 32'h000, 32'd0, 3, "b2b_miss0");
        exp_load_q.push_back(32'h22);
        access(1'b0, 32'h448, 32'd0, 0, "b2b_hit1");
        push_mem(1'b0, 32'h800, '0);
        exp_load_q.push_back(32'h31);
        access(1'b0, 32'h804, 32'd0, 3, "b2b_miss1");
        exp_load_q.push_back(32'h23);
        access(1'b0, 32'h44C, 32'd0, 0, "b2b_hit2");

        repeat (3) @(posedge clk);
        check32("load_q_empty", exp_load_q.size(), 32'd0);
        check32("mem_q_empty", exp_mem_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
